// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display blocks.
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'b11111100;
    localparam logic [7:0] SEG_1     = 8'b01100000;
    localparam logic [7:0] SEG_2     = 8'b11011010;
    localparam logic [7:0] SEG_3     = 8'b11110010;
    localparam logic [7:0] SEG_4     = 8'b01100110;
    localparam logic [7:0] SEG_5     = 8'b10110110;
    localparam logic [7:0] SEG_6     = 8'b10111110;
    localparam logic [7:0] SEG_7     = 8'b11100000;
    localparam logic [7:0] SEG_8     = 8'b11111110;
    localparam logic [7:0] SEG_9     = 8'b11110110;
    localparam logic [7:0] SEG_MINUS = 8'b00000010;
    localparam logic [7:0] SEG_OFF   = 8'h00;

    localparam logic [3:0] DIG_OFF   = 4'b1111;

    typedef enum logic {GAP, ON} state_t;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        blank_lz;
        logic [2:0]  bright;
    } frame_t;

    localparam frame_t FRAME_RST = '{bcd: 16'h0000, dp: 4'h0, blank_lz: 1'b0, bright: 3'd7};

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-load handshake plus segment/digit drive lines of the scan controller.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic        i_load;
    logic        o_ready;
    logic [15:0] i_bcd;
    logic [3:0]  i_dp;
    logic        i_blank_lz;
    logic [2:0]  i_bright;
    logic [7:0]  o_seg;
    logic [3:0]  o_dig;

    modport master (
        output i_load, i_bcd, i_dp, i_blank_lz, i_bright,
        input  o_ready, o_seg, o_dig
    );

    modport slave (
        input  i_load, i_bcd, i_dp, i_blank_lz, i_bright,
        output o_ready, o_seg, o_dig
    );

endinterface

// File: rtl/seg_decode.sv
// BCD nibble to active-high a..g,dp pattern; 10-15 show a minus sign.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] pattern;

    always_comb begin
        pattern = SEG_MINUS;
        case (nibble)
            4'd0: pattern = SEG_0;
            4'd1: pattern = SEG_1;
            4'd2: pattern = SEG_2;
            4'd3: pattern = SEG_3;
            4'd4: pattern = SEG_4;
            4'd5: pattern = SEG_5;
            4'd6: pattern = SEG_6;
            4'd7: pattern = SEG_7;
            4'd8: pattern = SEG_8;
            4'd9: pattern = SEG_9;
            default: pattern = SEG_MINUS;
        endcase
        // Blanking hides a..g only; the decimal point survives.
        seg = (blank ? SEG_OFF : pattern) | {7'b0000000, dp};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin 4-digit scan with anti-ghost gap, PWM brightness and
// frame-boundary commit of double-buffered display data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned TICK_WAIT = 27_000,
    parameter int unsigned DIGITS    = 4
) (
    input logic            i_clk,
    input logic            i_rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned CNT_W   = $clog2(TICK_WAIT);
    localparam int unsigned SUB_LEN = TICK_WAIT / 8;
    localparam int unsigned SUB_W   = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(TICK_WAIT - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SUB_LEN - 1);
    localparam logic [1:0]       LAST_DIG  = 2'(DIGITS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] slot_cnt, slot_nxt;
    logic [SUB_W-1:0] sub_cnt, sub_nxt;
    logic [2:0]       phase, phase_nxt;
    logic [1:0]       dig_idx, idx_nxt;
    frame_t           shadow, active, active_nxt;
    logic             ready_q, pending, accept, commit;
    logic [3:0]       lz_blank;
    logic [3:0]       nibble;
    logic [7:0]       dec_seg, seg_nxt, seg_q;
    logic [3:0]       dig_nxt, dig_q;

    assign accept  = bus.i_load && ready_q;
    assign pending = ~ready_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= GAP;
            slot_cnt <= '0;
            sub_cnt  <= '0;
            phase    <= '0;
            dig_idx  <= LAST_DIG;
            active   <= FRAME_RST;
            shadow   <= FRAME_RST;
            ready_q  <= 1'b1;
            seg_q    <= SEG_OFF;
            dig_q    <= DIG_OFF;
        end else begin
            state    <= state_nxt;
            slot_cnt <= slot_nxt;
            sub_cnt  <= sub_nxt;
            phase    <= phase_nxt;
            dig_idx  <= idx_nxt;
            active   <= active_nxt;
            if (accept) begin
                shadow  <= '{bcd: bus.i_bcd, dp: bus.i_dp,
                             blank_lz: bus.i_blank_lz, bright: bus.i_bright};
                ready_q <= 1'b0;
            end else if (commit) begin
                ready_q <= 1'b1;
            end
            seg_q <= seg_nxt;
            dig_q <= dig_nxt;
        end
    end

    // dig_idx still names the previous digit during GAP; it advances on GAP exit.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_cnt + CNT_W'(1);
        sub_nxt   = sub_cnt + SUB_W'(1);
        phase_nxt = phase;
        idx_nxt   = dig_idx;
        commit    = 1'b0;
        case (state)
            GAP: begin
                state_nxt = ON;
                idx_nxt   = (dig_idx == LAST_DIG) ? 2'd0 : dig_idx + 2'd1;
                commit    = pending && (dig_idx == LAST_DIG);
            end
            ON: begin
                if (slot_cnt == SLOT_LAST) state_nxt = GAP;
            end
            default: state_nxt = GAP;
        endcase
        if (slot_cnt == SLOT_LAST) begin
            slot_nxt  = '0;
            sub_nxt   = '0;
            phase_nxt = '0;
        end else if (sub_cnt == SUB_LAST) begin
            sub_nxt   = '0;
            phase_nxt = phase + 3'd1;
        end
        active_nxt = commit ? shadow : active;
    end

    // Outputs are registered, so they are built from next-cycle state and frame.
    assign lz_blank[3] = active_nxt.blank_lz && (active_nxt.bcd[15:12] == 4'd0);
    assign lz_blank[2] = lz_blank[3] && (active_nxt.bcd[11:8] == 4'd0);
    assign lz_blank[1] = lz_blank[2] && (active_nxt.bcd[7:4] == 4'd0);
    assign lz_blank[0] = 1'b0;
    assign nibble      = active_nxt.bcd[{idx_nxt, 2'b00} +: 4];

    seg_decode u_decode (
        .nibble (nibble),
        .dp     (active_nxt.dp[idx_nxt]),
        .blank  (lz_blank[idx_nxt]),
        .seg    (dec_seg)
    );

    always_comb begin
        dig_nxt = DIG_OFF;
        seg_nxt = SEG_OFF;
        if (state_nxt == ON) begin
            dig_nxt = ~(4'b0001 << idx_nxt);
            if (phase_nxt <= active_nxt.bright) seg_nxt = dec_seg;
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_seg   = seg_q;
    assign bus.o_dig   = dig_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with TICK_WAIT=16; t counts cycles since reset release.
module tb_seg_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   t = 0;
    int   checks = 0;
    int   errors = 0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.TICK_WAIT(16), .DIGITS(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        t++;
    endtask

    task automatic run_to(input int n);
        while (t < n) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0d: observed %b expected %b", tag, t, obs, exp);
        end
    endtask

    task automatic set_frame(input logic [15:0] bcd, input logic [3:0] dp,
                             input logic blz, input logic [2:0] br);
        bus.i_bcd      = bcd;
        bus.i_dp       = dp;
        bus.i_blank_lz = blz;
        bus.i_bright   = br;
    endtask

    function automatic logic [3:0] exp_dig(input int tt);
        int slot;
        int d;
        slot = tt % 16;
        d    = (tt / 16) % 4;
        return (slot == 0) ? 4'b1111 : ~(4'b0001 << d);
    endfunction

    initial begin
        bus.i_load = 1'b0;
        set_frame(16'h0000, 4'h0, 1'b0, 3'd7);
        repeat (3) tick();
        chk("rst_dig", {4'b0, bus.o_dig}, 8'h0F);
        chk("rst_seg", bus.o_seg, 8'h00);
        chk("rst_ready", {7'b0, bus.o_ready}, 8'h01);

        // Reset release: GAP for digit 0, then scan 0,1,2,3 showing '0'.
        rst = 1'b0;
        t   = 0;
        while (t < 64) begin
            chk("scan_dig", {4'b0, bus.o_dig}, {4'b0, exp_dig(t)});
            chk("scan_seg", bus.o_seg, (t % 16 == 0) ? 8'h00 : 8'b11111100);
            tick();
        end

        // Load mid-digit-1; commits at the digit-0 GAP at t=128.
        run_to(85);
        chk("load_ready_pre", {7'b0, bus.o_ready}, 8'h01);
        set_frame(16'h1234, 4'b0100, 1'b0, 3'd7);
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        chk("load_ready_drop", {7'b0, bus.o_ready}, 8'h00);
        run_to(100);
        chk("old_frame_dig", {4'b0, bus.o_dig}, 8'b00001011);
        chk("old_frame_seg", bus.o_seg, 8'b11111100);
        run_to(128);
        chk("commit_ready", {7'b0, bus.o_ready}, 8'h00);
        chk("commit_gap_dig", {4'b0, bus.o_dig}, 8'h0F);
        chk("commit_gap_seg", bus.o_seg, 8'h00);
        tick();
        chk("post_commit_ready", {7'b0, bus.o_ready}, 8'h01);
        chk("f1_d0_dig", {4'b0, bus.o_dig}, 8'b00001110);
        chk("f1_d0_seg", bus.o_seg, 8'b01100110);
        run_to(145);
        chk("f1_d1_dig", {4'b0, bus.o_dig}, 8'b00001101);
        chk("f1_d1_seg", bus.o_seg, 8'b11110010);
        run_to(161);
        chk("f1_d2_seg", bus.o_seg, 8'b11011011);
        run_to(177);
        chk("f1_d3_dig", {4'b0, bus.o_dig}, 8'b00000111);
        chk("f1_d3_seg", bus.o_seg, 8'b01100000);

        // Back-pressure: second frame offered while o_ready=0 must be dropped.
        run_to(180);
        chk("bp_ready_pre", {7'b0, bus.o_ready}, 8'h01);
        set_frame(16'h5678, 4'h0, 1'b0, 3'd7);
        bus.i_load = 1'b1;
        tick();
        chk("bp_ready_a", {7'b0, bus.o_ready}, 8'h00);
        set_frame(16'h9999, 4'hF, 1'b0, 3'd7);
        tick();
        bus.i_load = 1'b0;
        chk("bp_ready_b", {7'b0, bus.o_ready}, 8'h00);
        run_to(193);
        chk("bp_ready_post", {7'b0, bus.o_ready}, 8'h01);
        chk("bp_d0_seg", bus.o_seg, 8'b11111110);
        run_to(209);
        chk("bp_d1_seg", bus.o_seg, 8'b11100000);
        run_to(225);
        chk("bp_d2_seg", bus.o_seg, 8'b10111110);
        run_to(241);
        chk("bp_d3_seg", bus.o_seg, 8'b10110110);

        // Handshake on the commit GAP with nothing pending: waits a full frame.
        run_to(256);
        chk("cgap_dig", {4'b0, bus.o_dig}, 8'h0F);
        chk("cgap_ready", {7'b0, bus.o_ready}, 8'h01);
        set_frame(16'h0070, 4'b1000, 1'b1, 3'd7);
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        chk("cgap_ready_drop", {7'b0, bus.o_ready}, 8'h00);
        chk("cgap_old_d0", bus.o_seg, 8'b11111110);
        run_to(320);
        chk("lz_ready_wait", {7'b0, bus.o_ready}, 8'h00);

        // Leading-zero blanking of 0070, dp still shown on blanked digit 3.
        tick();
        chk("lz_ready", {7'b0, bus.o_ready}, 8'h01);
        chk("lz_d0_seg", bus.o_seg, 8'b11111100);
        run_to(337);
        chk("lz_d1_seg", bus.o_seg, 8'b11100000);
        run_to(353);
        chk("lz_d2_dig", {4'b0, bus.o_dig}, 8'b00001011);
        chk("lz_d2_seg", bus.o_seg, 8'h00);
        run_to(369);
        chk("lz_d3_dig", {4'b0, bus.o_dig}, 8'b00000111);
        chk("lz_d3_seg", bus.o_seg, 8'b00000001);

        run_to(370);
        set_frame(16'h0000, 4'h0, 1'b1, 3'd7);
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        run_to(385);
        chk("lz0_d0_seg", bus.o_seg, 8'b11111100);
        run_to(401);
        chk("lz0_d1_seg", bus.o_seg, 8'h00);

        // Brightness 1: lit only for slot 1..3 of each ON slot.
        run_to(402);
        set_frame(16'h8888, 4'h0, 1'b0, 3'd1);
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        run_to(449);
        while (t < 464) begin
            chk("br1_dig", {4'b0, bus.o_dig}, 8'b00001110);
            chk("br1_seg", bus.o_seg, ((t - 448) <= 3) ? 8'b11111110 : 8'h00);
            tick();
        end

        // Brightness 0: only the first ON cycle (phase 0) is lit.
        set_frame(16'h8888, 4'h0, 1'b0, 3'd0);
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        run_to(513);
        chk("br0_slot1", bus.o_seg, 8'b11111110);
        tick();
        chk("br0_slot2", bus.o_seg, 8'h00);

        // Reset mid-slot of digit 2 with a frame pending.
        run_to(520);
        set_frame(16'h4321, 4'h0, 1'b0, 3'd7);
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        chk("mr_pending", {7'b0, bus.o_ready}, 8'h00);
        run_to(550);
        chk("mr_pre_dig", {4'b0, bus.o_dig}, 8'b00001011);
        rst = 1'b1;
        tick();
        tick();
        chk("mr_rst_dig", {4'b0, bus.o_dig}, 8'h0F);
        chk("mr_rst_seg", bus.o_seg, 8'h00);
        chk("mr_rst_ready", {7'b0, bus.o_ready}, 8'h01);
        rst = 1'b0;
        t   = 0;
        chk("mr_gap_dig", {4'b0, bus.o_dig}, 8'h0F);
        tick();
        chk("mr_d0_dig", {4'b0, bus.o_dig}, 8'b00001110);
        chk("mr_d0_seg", bus.o_seg, 8'b11111100);
        chk("mr_ready", {7'b0, bus.o_ready}, 8'h01);
        run_to(15);
        chk("mr_bright7", bus.o_seg, 8'b11111100);
        run_to(65);
        chk("mr_f2_dig", {4'b0, bus.o_dig}, 8'b00001110);
        chk("mr_f2_seg", bus.o_seg, 8'b11111100);
        chk("mr_f2_ready", {7'b0, bus.o_ready}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
